// File: rtl/pq_cmd_frontend.sv
`timescale 1ns/1ps
// Command front end for the BRAM priority-queue tree: FIFO-buffered push/pop/replace,
// gap-spaced one-cycle strobes, one registered response per command. Optional macro: PQ_FRONTEND_STATS_EN.
module pq_cmd_frontend #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int ISSUE_GAP  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [1:0]            o_rsp_op,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_q_write,
  output logic                  o_q_read,
  output logic                  o_q_replace,
  output logic [DATA_WIDTH-1:0] o_q_new_item,
  input  logic                  i_q_full,
  input  logic                  i_q_empty,
  input  logic [DATA_WIDTH-1:0] i_q_top_item,
  output logic                  o_busy,
  output logic                  o_dbg_state
`ifdef PQ_FRONTEND_STATS_EN
  ,
  output logic [31:0]           o_stat_issued,
  output logic [31:0]           o_stat_rejected
`endif
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(CMD_DEPTH);
  localparam logic [GW-1:0] GAP_INIT = GW'(ISSUE_GAP - 1);

  // Both interfaces transfer on a rising edge where valid && ready; a producer
  // never lowers valid or changes payload while waiting for ready.
  typedef enum logic { S_IDLE = 1'b0, S_GAP = 1'b1 } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [1:0]            fifo_op_q   [CMD_DEPTH];
  logic [1:0]            fifo_op_d   [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [CMD_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_op_q, rsp_op_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  cmd_ready, accept, slot_free, issue;
  logic [1:0]            head_op;
  logic [DATA_WIDTH-1:0] head_data, ev_data, q_new_item;
  logic                  ev_err, q_write, q_read, q_replace;

  assign cmd_ready = (count_q < DEPTH_C);
  assign accept    = i_cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid_q || i_rsp_ready;
  assign head_op   = fifo_op_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  // Gating with RST keeps the queue untouched in the reset cycle itself.
  assign issue     = (state_q == S_IDLE) && (count_q != '0) && slot_free && !RST;

  always_comb begin
    q_write    = 1'b0;
    q_read     = 1'b0;
    q_replace  = 1'b0;
    q_new_item = '0;
    ev_data    = '0;
    ev_err     = 1'b0;
    if (issue) begin
      case (head_op)
        2'b00: begin
          ev_data = head_data;
          if (!i_q_full) begin
            q_write    = 1'b1;
            q_new_item = head_data;
          end else begin
            ev_err = 1'b1;
          end
        end
        2'b01: begin
          if (!i_q_empty) begin
            q_read  = 1'b1;
            ev_data = i_q_top_item;
          end else begin
            ev_err = 1'b1;
          end
        end
        2'b10: begin
          if (!i_q_empty) begin
            q_replace  = 1'b1;
            q_new_item = head_data;
            ev_data    = i_q_top_item;
          end else begin
            ev_err = 1'b1;
          end
        end
        default: ev_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (issue && (ISSUE_GAP > 1)) begin
          state_d = S_GAP;
          gap_d   = GAP_INIT;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_op_d   = fifo_op_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (accept) begin
      fifo_op_d[wr_ptr_q]   = i_cmd_op;
      fifo_data_d[wr_ptr_q] = i_cmd_data;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({accept, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_op_d    = head_op;
      rsp_data_d  = ev_data;
      rsp_err_d   = ev_err;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fifo_op_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      fifo_op_q   <= fifo_op_d;
      fifo_data_q <= fifo_data_d;
    end
  end

`ifdef PQ_FRONTEND_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_rejected_q, stat_rejected_d;

  always_comb begin
    stat_issued_d   = stat_issued_q;
    stat_rejected_d = stat_rejected_q;
    if ((q_write || q_read || q_replace) && (stat_issued_q != '1))
      stat_issued_d = stat_issued_q + 32'd1;
    if (issue && ev_err && (stat_rejected_q != '1))
      stat_rejected_d = stat_rejected_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_issued_q   <= '0;
      stat_rejected_q <= '0;
    end else begin
      stat_issued_q   <= stat_issued_d;
      stat_rejected_q <= stat_rejected_d;
    end
  end

  assign o_stat_issued   = stat_issued_q;
  assign o_stat_rejected = stat_rejected_q;
`endif

  assign o_cmd_ready  = cmd_ready;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_op     = rsp_op_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_q_write    = q_write;
  assign o_q_read     = q_read;
  assign o_q_replace  = q_replace;
  assign o_q_new_item = q_new_item;
  assign o_busy       = (count_q != '0) || (state_q != S_IDLE) || rsp_valid_q;
  assign o_dbg_state  = state_q;

endmodule
